// File: rtl/ysyx_22040759_lsu_axi_pkg.sv
// Shared definitions for the LSU: func3 codes, FSM states, AXI resp/size/burst encodings.
// Combinational helpers only; no latency, no backpressure.
// Imported by the LSU top and its alignment sub-module.
package ysyx_22040759_lsu_axi_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_1B = 3'b000;
    localparam logic [2:0] SIZE_2B = 3'b001;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [2:0] SIZE_8B = 3'b011;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } lsu_state_e;

    // Request fields captured at acceptance and held for the whole transaction.
    typedef struct packed {
        logic [2:0]  func3;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } lsu_req_t;

    function automatic logic [2:0] size_of(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return SIZE_1B;
            2'b01:   return SIZE_2B;
            2'b10:   return SIZE_4B;
            default: return SIZE_8B;
        endcase
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp & RESP_SLVERR) != RESP_OKAY;
    endfunction

    function automatic logic misaligned(input logic [2:0] func3, input logic [2:0] off);
        case (func3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Lane alignment: store strobe/data shift and load shift/extend keyed by func3 and byte offset.
// Purely combinational, zero latency.
// No backpressure; bytes shifted past lane 7 fall off the top.
module ysyx_22040759_lsu_align
    import ysyx_22040759_lsu_axi_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [2:0]  off,
    input  logic [63:0] st_data,
    input  logic [63:0] ld_data,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] rdata
);

    logic [5:0]  sh;
    logic [63:0] ld_sh;

    assign sh = {off, 3'b000};

    always_comb begin
        wdata = st_data << sh;
        ld_sh = ld_data >> sh;

        case (func3)
            F3_SB:   wstrb = 8'h01 << off;
            F3_SH:   wstrb = 8'h03 << off;
            F3_SW:   wstrb = 8'h0F << off;
            default: wstrb = 8'hFF;
        endcase

        case (func3)
            F3_LB:   rdata = {{56{ld_sh[7]}},  ld_sh[7:0]};
            F3_LH:   rdata = {{48{ld_sh[15]}}, ld_sh[15:0]};
            F3_LW:   rdata = {{32{ld_sh[31]}}, ld_sh[31:0]};
            F3_LD:   rdata = ld_sh;
            F3_LBU:  rdata = {56'd0, ld_sh[7:0]};
            F3_LHU:  rdata = {48'd0, ld_sh[15:0]};
            F3_LWU:  rdata = {32'd0, ld_sh[31:0]};
            default: rdata = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_lsu_axi.sv
// LSU AXI4 master: one single-beat read or write per MEM-stage request; YSYX_22040759_MISALIGN_CHECK_EN adds misalignment trapping.
// Latency: 3 cycles request-to-done with a zero-wait slave; misaligned trap completes next cycle.
// Backpressure: lsu_stall holds the pipeline until the bus responds; AXI valids hold until their handshake.
module ysyx_22040759_lsu_axi
    import ysyx_22040759_lsu_axi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req_valid,
    input  logic              lsu_req_wen,
    input  logic [2:0]        lsu_func3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    input  logic              rlast,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [2:0]        awsize,
    output logic [7:0]        awlen,
    output logic [1:0]        awburst,
    output logic [3:0]        awid,
    output logic [DATA_W-1:0] wdata,
    output logic [7:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state, state_nxt;
    lsu_req_t          req;
    logic [ADDR_W-1:0] req_addr;
    logic              aw_done, w_done;
    logic              accept, misalign;
    logic [2:0]        aln_func3, aln_off;
    logic [7:0]        aln_wstrb;
    logic [63:0]       aln_wdata, aln_rdata;
    logic              unused_rlast;

    assign unused_rlast = rlast;

    // The done cycle still sees the completed request on the inputs; it must not be re-accepted.
    assign accept    = (state == ST_IDLE) && lsu_req_valid && !lsu_done;
    assign lsu_stall = accept || (state != ST_IDLE);

`ifdef YSYX_22040759_MISALIGN_CHECK_EN
    assign misalign = misaligned(lsu_func3, lsu_addr[2:0]);
`else
    assign misalign = 1'b0;
`endif

    // Live request fields feed the store path in IDLE; latched ones feed the load path later.
    assign aln_func3 = (state == ST_IDLE) ? lsu_func3     : req.func3;
    assign aln_off   = (state == ST_IDLE) ? lsu_addr[2:0] : req_addr[2:0];

    ysyx_22040759_lsu_align u_align (
        .func3   (aln_func3),
        .off     (aln_off),
        .st_data (lsu_wdata),
        .ld_data (rdata),
        .wstrb   (aln_wstrb),
        .wdata   (aln_wdata),
        .rdata   (aln_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && !misalign)
                    state_nxt = lsu_req_wen ? ST_WREQ : ST_RADDR;
            end
            ST_RADDR: if (arready) state_nxt = ST_RDATA;
            ST_RDATA: if (rvalid)  state_nxt = ST_IDLE;
            ST_WREQ: begin
                if ((aw_done || awready) && (w_done || wready))
                    state_nxt = ST_WRESP;
            end
            ST_WRESP: if (bvalid) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state)
            ST_RADDR: arvalid = 1'b1;
            ST_RDATA: rready  = 1'b1;
            ST_WREQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
            end
            ST_WRESP: bready = 1'b1;
            default: ;
        endcase
        wlast = wvalid;
    end

    assign araddr  = req_addr;
    assign awaddr  = req_addr;
    assign arsize  = size_of(req.func3);
    assign awsize  = size_of(req.func3);
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arid    = 4'd0;
    assign awid    = 4'd0;
    assign wdata   = req.wdata;
    assign wstrb   = req.wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            req       <= '0;
            req_addr  <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            lsu_done  <= 1'b0;
            lsu_rdata <= '0;
            lsu_err   <= 1'b0;
        end else begin
            lsu_done <= 1'b0;
            if (accept) begin
                req_addr  <= lsu_addr;
                req.func3 <= lsu_func3;
                req.wdata <= aln_wdata;
                req.wstrb <= aln_wstrb;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                if (misalign) begin
                    lsu_done  <= 1'b1;
                    lsu_err   <= 1'b1;
                    lsu_rdata <= '0;
                end
            end
            if (state == ST_WREQ) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
            if (state == ST_RDATA && rvalid) begin
                lsu_done  <= 1'b1;
                lsu_rdata <= aln_rdata;
                lsu_err   <= resp_is_err(rresp);
            end
            if (state == ST_WRESP && bvalid) begin
                lsu_done  <= 1'b1;
                lsu_rdata <= '0;
                lsu_err   <= resp_is_err(bresp);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_lsu_axi.sv
// Directed bench for the LSU AXI master; the bus slave is driven by hand, step by step.
module tb_ysyx_22040759_lsu_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_valid, lsu_req_wen;
    logic [2:0]  lsu_func3;
    logic [63:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [63:0] lsu_rdata;
    logic [63:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [2:0]  arsize, awsize;
    logic [7:0]  arlen, awlen, wstrb;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [3:0]  arid, awid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22040759_lsu_axi dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
        .lsu_func3(lsu_func3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
        .arlen(arlen), .arburst(arburst), .arid(arid),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awsize(awsize),
        .awlen(awlen), .awburst(awburst), .awid(awid),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wen, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd);
        lsu_req_valid = 1'b1;
        lsu_req_wen   = wen;
        lsu_func3     = f3;
        lsu_addr      = addr;
        lsu_wdata     = wd;
    endtask

    task automatic bus_idle();
        lsu_req_valid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        lsu_req_wen = 1'b0; lsu_func3 = 3'b000; lsu_addr = '0; lsu_wdata = '0;
        bus_idle();
        tick(); tick();
        check("rst_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst_awvalid", {63'd0, awvalid}, 64'd0);
        check("rst_wvalid",  {63'd0, wvalid},  64'd0);
        check("rst_rready",  {63'd0, rready},  64'd0);
        check("rst_bready",  {63'd0, bready},  64'd0);
        check("rst_done",    {63'd0, lsu_done}, 64'd0);
        check("rst_rdata",   lsu_rdata, 64'd0);
        check("rst_err",     {63'd0, lsu_err}, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_stall",  {63'd0, lsu_stall}, 64'd0);

        // lb at offset 3: byte 0x80 sign-extends
        request(1'b0, 3'b000, 64'h8000_0003, 64'd0);
        #1 check("lb_stall_c0", {63'd0, lsu_stall}, 64'd1);
        tick();
        check("lb_arvalid_c1", {63'd0, arvalid}, 64'd1);
        check("lb_araddr", araddr, 64'h8000_0003);
        check("lb_arsize", {61'd0, arsize}, 64'd0);
        check("lb_arlen", {56'd0, arlen}, 64'd0);
        check("lb_arburst", {62'd0, arburst}, 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("lb_arvalid_c2", {63'd0, arvalid}, 64'd0);
        check("lb_rready_c2", {63'd0, rready}, 64'd1);
        rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0000_8000_0000;
        tick();
        bus_idle();
        check("lb_done_c3", {63'd0, lsu_done}, 64'd1);
        check("lb_rdata", lsu_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_err", {63'd0, lsu_err}, 64'd0);
        check("lb_stall_c3", {63'd0, lsu_stall}, 64'd0);
        tick();
        check("lb_done_c4", {63'd0, lsu_done}, 64'd0);

        // lwu at offset 4: upper word zero-extended
        request(1'b0, 3'b110, 64'h0000_1004, 64'd0);
        tick();
        check("lwu_arsize", {61'd0, arsize}, 64'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0000_0000;
        tick();
        bus_idle();
        check("lwu_done", {63'd0, lsu_done}, 64'd1);
        check("lwu_rdata", lsu_rdata, 64'h0000_0000_DEAD_BEEF);
        tick();

        // sh at offset 6; wready first, awready three cycles later
        request(1'b1, 3'b001, 64'h0000_2006, 64'h0000_0000_0000_1234);
        tick();
        check("sh_awvalid_c1", {63'd0, awvalid}, 64'd1);
        check("sh_wvalid_c1", {63'd0, wvalid}, 64'd1);
        check("sh_wstrb", {56'd0, wstrb}, 64'h00C0);
        check("sh_wdata", wdata, 64'h1234_0000_0000_0000);
        check("sh_awaddr", awaddr, 64'h0000_2006);
        check("sh_awsize", {61'd0, awsize}, 64'd1);
        check("sh_wlast", {63'd0, wlast}, 64'd1);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("sh_wvalid_c2", {63'd0, wvalid}, 64'd0);
        check("sh_awvalid_c2", {63'd0, awvalid}, 64'd1);
        tick();
        check("sh_awvalid_c3", {63'd0, awvalid}, 64'd1);
        check("sh_bready_c3", {63'd0, bready}, 64'd0);
        tick();
        check("sh_awaddr_hold", awaddr, 64'h0000_2006);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("sh_awvalid_c5", {63'd0, awvalid}, 64'd0);
        check("sh_bready_c5", {63'd0, bready}, 64'd1);
        check("sh_stall_c5", {63'd0, lsu_stall}, 64'd1);
        check("sh_done_c5", {63'd0, lsu_done}, 64'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bus_idle();
        check("sh_done_c6", {63'd0, lsu_done}, 64'd1);
        check("sh_err", {63'd0, lsu_err}, 64'd0);
        tick();

        // sd with SLVERR, then an ordinary ld
        request(1'b1, 3'b011, 64'h0000_3000, 64'h0123_4567_89AB_CDEF);
        tick();
        check("sd_wstrb", {56'd0, wstrb}, 64'h00FF);
        check("sd_wdata", wdata, 64'h0123_4567_89AB_CDEF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        check("sd_bready", {63'd0, bready}, 64'd1);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bus_idle();
        check("sd_done", {63'd0, lsu_done}, 64'd1);
        check("sd_err", {63'd0, lsu_err}, 64'd1);
        tick();
        request(1'b0, 3'b011, 64'h0000_3000, 64'd0);
        tick();
        check("ld_arvalid", {63'd0, arvalid}, 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 64'h1122_3344_5566_7788;
        tick();
        bus_idle();
        check("ld_done", {63'd0, lsu_done}, 64'd1);
        check("ld_rdata", lsu_rdata, 64'h1122_3344_5566_7788);
        check("ld_err", {63'd0, lsu_err}, 64'd0);
        tick();

        // reset in RDATA drops the transaction; a late rvalid is ignored
        request(1'b0, 3'b010, 64'h0000_4000, 64'd0);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rst_mid_rready", {63'd0, rready}, 64'd1);
        rst = 1'b1; lsu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_mid_rready_after", {63'd0, rready}, 64'd0);
        check("rst_mid_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst_mid_done", {63'd0, lsu_done}, 64'd0);
        check("rst_mid_stall", {63'd0, lsu_stall}, 64'd0);
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus_idle();
        check("rst_mid_no_done", {63'd0, lsu_done}, 64'd0);
        check("rst_mid_rready_idle", {63'd0, rready}, 64'd0);
        tick();

        // lw at offset 2
        request(1'b0, 3'b010, 64'h0000_5002, 64'd0);
        tick();
`ifdef YSYX_22040759_MISALIGN_CHECK_EN
        check("mis_arvalid", {63'd0, arvalid}, 64'd0);
        check("mis_done", {63'd0, lsu_done}, 64'd1);
        check("mis_err", {63'd0, lsu_err}, 64'd1);
        check("mis_rdata", lsu_rdata, 64'd0);
        check("mis_stall", {63'd0, lsu_stall}, 64'd0);
        bus_idle();
        tick();
        check("mis_done_after", {63'd0, lsu_done}, 64'd0);
        check("mis_no_arvalid", {63'd0, arvalid}, 64'd0);
`else
        check("unal_arvalid", {63'd0, arvalid}, 64'd1);
        check("unal_araddr", araddr, 64'h0000_5002);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 64'h0000_AABB_CCDD_0000;
        tick();
        bus_idle();
        check("unal_done", {63'd0, lsu_done}, 64'd1);
        check("unal_rdata", lsu_rdata, 64'hFFFF_FFFF_AABB_CCDD);
        check("unal_err", {63'd0, lsu_err}, 64'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
